// File: rtl/wb_interconnect_rr_arb_wdt.sv
// wb_interconnect_rr_arb_wdt: per-target round-robin arbiter with ownership lock and no-ack watchdog
module wb_interconnect_rr_arb_wdt #(
    parameter int N_REQ = 2,
    parameter int TIMEOUT = 256,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             tack,
    input  logic             terr,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    output logic             timeout,
    output logic [ID_W-1:0]  timeout_id
);
    typedef enum logic {IDLE, OWN} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    state_t state, state_n;
    logic [N_REQ-1:0] mask, mask_n, gnt_n, elig, cand, own_oh;
    logic [ID_W-1:0] ptr, ptr_n, gnt_id_n, timeout_id_n, start, after, win, idx;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic found, expire, rel, timeout_n;
    assign gnt_valid = |gnt;
    assign own_oh = N_REQ'(1) << gnt_id;
    assign after = ID_W'((int'(gnt_id) + 1) % N_REQ);
    assign elig = req & ~mask;
    assign expire = (TIMEOUT > 0) && state == OWN && req[gnt_id] && !(tack || terr) && cnt == LAST;
    assign rel = state == OWN && (!req[gnt_id] || expire);
    assign cand = (state == OWN) ? (elig & ~own_oh) : elig;
    assign start = (state == OWN) ? after : ptr;
    // first set candidate scanning upward from start with wrap; reverse loop so the nearest one wins
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ID_W'((int'(start) + i) % N_REQ);
            if (cand[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end
    // next state: grant from idle or hand over on release, otherwise hold and run the watchdog
    always_comb begin
        state_n = state;
        gnt_n = gnt;
        gnt_id_n = gnt_id;
        ptr_n = ptr;
        cnt_n = cnt;
        timeout_n = expire;
        timeout_id_n = expire ? gnt_id : timeout_id;
        mask_n = (TIMEOUT > 0) ? ((mask & req) | (expire ? own_oh : '0)) : '0;
        if (state == IDLE || rel) begin
            ptr_n = rel ? after : ptr;
            state_n = found ? OWN : IDLE;
            gnt_n = found ? (N_REQ'(1) << win) : '0;
            gnt_id_n = found ? win : '0;
            cnt_n = '0;
        end else begin
            cnt_n = (TIMEOUT == 0 || tack || terr) ? '0 : ((cnt == '1) ? cnt : cnt + 1'b1);
        end
    end
    // state registers; reset drops any grant immediately
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            gnt <= '0;
            gnt_id <= '0;
            ptr <= '0;
            cnt <= '0;
            mask <= '0;
            timeout <= 1'b0;
            timeout_id <= '0;
        end else begin
            state <= state_n;
            gnt <= gnt_n;
            gnt_id <= gnt_id_n;
            ptr <= ptr_n;
            cnt <= cnt_n;
            mask <= mask_n;
            timeout <= timeout_n;
            timeout_id <= timeout_id_n;
        end
    end
endmodule

// File: tb/tb_wb_interconnect_rr_arb_wdt.sv
// tb_wb_interconnect_rr_arb_wdt: three arbiter configurations checked against a behavioural model
module tb_wb_interconnect_rr_arb_wdt;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] req;
    logic tack, terr;
    logic [3:0] gnt0, gnt1;
    logic [1:0] gnt2;
    logic gv0, gv1, gv2, to0, to1, to2;
    logic [1:0] id0, id1, tid0, tid1;
    logic id2, tid2;
    int checks = 0;
    int errors = 0;
    logic seen0, seen1;

    wb_interconnect_rr_arb_wdt #(.N_REQ(4), .TIMEOUT(8)) u0 (
        .clock(clock), .reset_n(reset_n), .req(req), .tack(tack), .terr(terr),
        .gnt(gnt0), .gnt_valid(gv0), .gnt_id(id0), .timeout(to0), .timeout_id(tid0));
    wb_interconnect_rr_arb_wdt #(.N_REQ(4), .TIMEOUT(0)) u1 (
        .clock(clock), .reset_n(reset_n), .req(req), .tack(tack), .terr(terr),
        .gnt(gnt1), .gnt_valid(gv1), .gnt_id(id1), .timeout(to1), .timeout_id(tid1));
    wb_interconnect_rr_arb_wdt #(.N_REQ(2), .TIMEOUT(8)) u2 (
        .clock(clock), .reset_n(reset_n), .req(req[1:0]), .tack(tack), .terr(terr),
        .gnt(gnt2), .gnt_valid(gv2), .gnt_id(id2), .timeout(to2), .timeout_id(tid2));

    initial forever #5 clock = ~clock;

    logic [3:0] ag [3];
    logic [1:0] ai [3];
    logic [1:0] ati [3];
    logic av [3];
    logic at [3];
    assign ag[0] = gnt0;
    assign ag[1] = gnt1;
    assign ag[2] = {2'b00, gnt2};
    assign ai[0] = id0;
    assign ai[1] = id1;
    assign ai[2] = {1'b0, id2};
    assign ati[0] = tid0;
    assign ati[1] = tid1;
    assign ati[2] = {1'b0, tid2};
    assign av[0] = gv0;
    assign av[1] = gv1;
    assign av[2] = gv2;
    assign at[0] = to0;
    assign at[1] = to1;
    assign at[2] = to2;

    // model state: owner index (-1 when idle), rotation start, stall cycles, blocked initiators
    typedef struct packed {
        int own;
        int ptr;
        int cnt;
        int tid;
        logic to;
        logic [3:0] msk;
    } mst_t;
    mst_t ms [3];

    function automatic int pick(logic [3:0] v, int start, int n);
        for (int i = 0; i < n; i++)
            if (((v >> ((start + i) % n)) & 4'd1) != 4'd0) return (start + i) % n;
        return -1;
    endfunction

    function automatic mst_t rst_st();
        mst_t x;
        x.own = -1;
        x.ptr = 0;
        x.cnt = 0;
        x.tid = 0;
        x.to = 1'b0;
        x.msk = 4'd0;
        return x;
    endfunction

    function automatic mst_t step(mst_t s, int n, int t, logic [3:0] rq, logic ak);
        mst_t x;
        logic [3:0] r, el;
        logic fire, held;
        x = s;
        r = rq & 4'((1 << n) - 1);
        el = r & ~s.msk;
        fire = 1'b0;
        if (s.own < 0) begin
            x.own = pick(el, s.ptr, n);
            x.cnt = 0;
        end else begin
            held = r[s.own[1:0]];
            fire = held && t > 0 && !ak && s.cnt >= t - 1;
            if (!held || fire) begin
                x.ptr = (s.own + 1) % n;
                el[s.own[1:0]] = 1'b0;
                x.own = pick(el, x.ptr, n);
                x.cnt = 0;
            end else begin
                x.cnt = ak ? 0 : s.cnt + 1;
            end
        end
        x.msk = (t > 0) ? ((s.msk & r) | (fire ? 4'(1 << s.own) : 4'd0)) : 4'd0;
        x.to = fire;
        if (fire) x.tid = s.own;
        return x;
    endfunction

    initial forever begin
        @(posedge clock or negedge reset_n);
        for (int k = 0; k < 3; k++)
            ms[k] = !reset_n ? rst_st() : step(ms[k], (k == 2) ? 2 : 4, (k == 1) ? 0 : 8, req, tack | terr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        int o;
        for (int k = 0; k < 3; k++) begin
            o = ms[k].own;
            chk($sformatf("u%0d.gnt", k), 32'(ag[k]), (o < 0) ? 32'd0 : 32'(1 << o));
            chk($sformatf("u%0d.gnt_valid", k), 32'(av[k]), 32'(o >= 0));
            chk($sformatf("u%0d.gnt_id", k), 32'(ai[k]), (o < 0) ? 32'd0 : 32'(o));
            chk($sformatf("u%0d.timeout", k), 32'(at[k]), 32'(ms[k].to));
            chk($sformatf("u%0d.timeout_id", k), 32'(ati[k]), 32'(ms[k].tid));
        end
    endtask

    initial begin
        @(posedge reset_n);
        forever begin
            @(negedge clock);
            compare_all();
        end
    end

    initial begin
        req = 4'd0;
        tack = 1'b0;
        terr = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle_gnt", 32'(gnt0), 0);
            chk("idle_valid", 32'(gv0), 0);
            chk("idle_timeout", 32'(to0), 0);
        end
        // latency and lock
        tack = 1'b1;
        req = 4'b0001;
        @(negedge clock);
        chk("latency_gnt", 32'(gnt0), 1);
        chk("latency_gnt_n2", 32'(gnt2), 1);
        repeat (2) @(negedge clock);
        req = 4'b0011;
        repeat (3) @(negedge clock);
        chk("lock_gnt", 32'(gnt0), 1);
        req = 4'b0010;
        @(negedge clock);
        chk("handover_gnt", 32'(gnt0), 2);
        chk("handover_gnt_n2", 32'(gnt2), 2);
        // round-robin fairness from a fresh pointer
        req = 4'd0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        req = 4'hf;
        @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("fair_order%0d", k), 32'(gnt0), 32'(1 << (k % 4)));
            @(negedge clock);
            req = 4'hf & ~4'(1 << (k % 4));
            @(negedge clock);
            req = 4'hf;
        end
        // watchdog expiry with a pending requester
        req = 4'd0;
        @(negedge clock);
        req = 4'b0100;
        tack = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            chk("wd_hold", 32'(gnt0), 4);
            if (i == 1) req = 4'b0101;
        end
        @(negedge clock);
        chk("wd_next_gnt", 32'(gnt0), 1);
        chk("wd_next_id", 32'(id0), 0);
        chk("wd_timeout", 32'(to0), 1);
        chk("wd_timeout_id", 32'(tid0), 2);
        chk("wd_off_hold", 32'(gnt1), 4);
        chk("wd_off_timeout", 32'(to1), 0);
        tack = 1'b1;
        @(negedge clock);
        chk("wd_pulse_end", 32'(to0), 0);
        chk("wd_id_hold", 32'(tid0), 2);
        req = 4'b0100;
        repeat (3) begin
            @(negedge clock);
            chk("wd_masked", 32'(gnt0), 0);
        end
        req = 4'd0;
        @(negedge clock);
        req = 4'b0100;
        @(negedge clock);
        chk("wd_regrant", 32'(gnt0), 4);
        // periodic kicks keep the owner alive
        seen0 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tack = (i % 14 == 0);
            terr = (i % 14 == 7);
            @(negedge clock);
            seen0 |= to0;
        end
        terr = 1'b0;
        chk("kick_no_timeout", 32'(seen0), 0);
        chk("kick_gnt", 32'(gnt0), 4);
        // ack on the expiry cycle, then owner drop on the expiry cycle
        tack = 1'b1;
        @(negedge clock);
        tack = 1'b0;
        repeat (7) @(negedge clock);
        tack = 1'b1;
        @(negedge clock);
        chk("ack_edge_gnt", 32'(gnt0), 4);
        chk("ack_edge_timeout", 32'(to0), 0);
        tack = 1'b0;
        repeat (7) @(negedge clock);
        req = 4'd0;
        @(negedge clock);
        chk("drop_edge_gnt", 32'(gnt0), 0);
        chk("drop_edge_timeout", 32'(to0), 0);
        // disabled watchdog under a long stall
        seen1 = 1'b0;
        req = 4'b0010;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            seen1 |= to1;
        end
        chk("off_no_timeout", 32'(seen1), 0);
        chk("off_gnt", 32'(gnt1), 2);
        chk("on_timeout_id", 32'(tid0), 1);
        chk("on_masked", 32'(gnt0), 0);
        // asynchronous reset between edges
        req = 4'd0;
        tack = 1'b1;
        @(negedge clock);
        req = 4'b0100;
        @(negedge clock);
        chk("areset_pre", 32'(gnt0), 4);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_gnt", 32'(gnt0), 0);
        chk("areset_valid", 32'(gv0), 0);
        chk("areset_gnt_off", 32'(gnt1), 0);
        @(negedge clock);
        req = 4'hf;
        reset_n = 1'b1;
        @(negedge clock);
        chk("areset_ptr_gnt", 32'(gnt0), 1);
        chk("areset_ptr_id", 32'(id0), 0);
        chk("areset_ptr_n2", 32'(gnt2), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
